// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: registered state, control outputs decoded combinationally from it.
// Latency: R/I/sw 4, lw 5, branch/jump 3 cycles; each MemReady-low cycle in a memory state adds one stall.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADDR  = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXEC_R   = 4'd6;
    localparam logic [3:0] RWB      = 4'd7;
    localparam logic [3:0] EXEC_I   = 4'd8;
    localparam logic [3:0] IWB      = 4'd9;
    localparam logic [3:0] BRANCH   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctl_t;

    logic [3:0] state_q, state_d;
    ctl_t       ctl;
    ctl_t       ctl_gated;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        ctl     = '0;
        state_d = FETCH;
        case (state_q)
            FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                // Mealy: PC and IR load in the same cycle memory returns the instruction
                ctl.ir_write  = MemReady;
                ctl.pc_write  = MemReady;
                state_d       = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ctl.alu_src_b = 2'b11;
                case (OP)
                    OP_LW, OP_SW:                      state_d = MEMADDR;
                    OP_R:                              state_d = EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_d = EXEC_I;
                    OP_BEQ, OP_BNE:                    state_d = BRANCH;
                    OP_J:                              state_d = JUMP;
                    default:                           ctl.illegal_op = 1'b1;
                endcase
            end
            MEMADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                state_d       = (OP == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                ctl.iord     = 1'b1;
                ctl.mem_read = 1'b1;
                state_d      = MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
                state_d       = MemReady ? FETCH : MEMWRITE;
            end
            EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 3'b111;
                state_d       = RWB;
            end
            RWB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
            end
            EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                case (OP)
                    OP_ADDI: ctl.alu_op = 3'b010;
                    OP_ANDI: ctl.alu_op = 3'b100;
                    OP_ORI:  ctl.alu_op = 3'b101;
                    OP_LUI:  ctl.alu_op = 3'b110;
                    default: ctl.alu_op = 3'b000;
                endcase
                state_d = IWB;
            end
            IWB: ctl.reg_write = 1'b1;
            BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 3'b001;
                ctl.pc_source = 2'b01;
                ctl.pc_write  = ((OP == OP_BEQ) && Zero) || ((OP == OP_BNE) && !Zero);
            end
            JUMP: begin
                ctl.pc_source = 2'b10;
                ctl.pc_write  = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

    // Reset also masks the Mealy FETCH terms, so outputs drop the moment reset asserts
    assign ctl_gated = reset ? ctl : '0;

    assign PCWrite   = ctl_gated.pc_write;
    assign IorD      = ctl_gated.iord;
    assign MemRead   = ctl_gated.mem_read;
    assign MemWrite  = ctl_gated.mem_write;
    assign IRWrite   = ctl_gated.ir_write;
    assign MemtoReg  = ctl_gated.mem_to_reg;
    assign RegDst    = ctl_gated.reg_dst;
    assign RegWrite  = ctl_gated.reg_write;
    assign ALUSrcA   = ctl_gated.alu_src_a;
    assign ALUSrcB   = ctl_gated.alu_src_b;
    assign ALUOp     = ctl_gated.alu_op;
    assign PCSource  = ctl_gated.pc_source;
    assign IllegalOp = ctl_gated.illegal_op;
    assign State     = state_q;
endmodule
